// File: rtl/mgt_wb_initiator.sv
// mgt_wb_initiator: single-outstanding Wishbone classic initiator.
// Accepts one command over a valid/ready handshake, runs exactly one bus
// cycle and returns read data plus status over a second valid/ready handshake.
// Optional hung-cycle timeout is compiled in with MGT_WB_INITIATOR_TIMEOUT_EN.
module mgt_wb_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        mgt_wb_clk_i,
    input  logic        mgt_wb_rst_i,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] STATUS_OK  = 2'b00;
    localparam logic [1:0] STATUS_ERR = 2'b01;

    // The counter is only 8 bits wide, so reject out-of-range settings early.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mgt_wb_initiator: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef MGT_WB_INITIATOR_TIMEOUT_EN
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
    localparam logic [7:0] TIMEOUT_LIMIT  = 8'(TIMEOUT_CYCLES);

    logic [7:0] timeout_cnt;
`endif

    state_t state;

    // Read data returned on an ack: writes report zero so the requester never
    // sees stale bus data attached to a write response.
    function automatic logic [31:0] ack_data(input logic is_write,
                                             input logic [31:0] bus_data);
        return is_write ? 32'h0 : bus_data;
    endfunction

    // Command/response FSM with every output registered.
    always_ff @(posedge mgt_wb_clk_i) begin
        if (mgt_wb_rst_i) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_status <= STATUS_OK;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= 4'h0;
            wbm_adr_o  <= 32'h0;
            wbm_dat_o  <= 32'h0;
`ifdef MGT_WB_INITIATOR_TIMEOUT_EN
            timeout_cnt <= 8'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_wdata;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
`ifdef MGT_WB_INITIATOR_TIMEOUT_EN
                        timeout_cnt <= 8'h0;
`endif
                        state     <= BUS;
                    end
                end

                BUS: begin
                    // Error outranks ack, ack outranks timeout.
                    if (wbm_err_i) begin
                        rsp_rdata  <= 32'h0;
                        rsp_status <= STATUS_ERR;
                        rsp_valid  <= 1'b1;
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        state      <= RESP;
                    end else if (wbm_ack_i) begin
                        rsp_rdata  <= ack_data(wbm_we_o, wbm_dat_i);
                        rsp_status <= STATUS_OK;
                        rsp_valid  <= 1'b1;
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        state      <= RESP;
                    end
`ifdef MGT_WB_INITIATOR_TIMEOUT_EN
                    else if (timeout_cnt == TIMEOUT_LIMIT) begin
                        rsp_rdata  <= 32'h0;
                        rsp_status <= STATUS_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        state      <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
`endif
                end

                RESP: begin
                    // cmd_ready rises only after the handshake edge, so a new
                    // command is never accepted in the handshake cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mgt_wb_initiator.sv
// Bench for mgt_wb_initiator: table of single transactions plus hand-written
// sequences for timeout, stray terminations, backpressure and mid-cycle reset.
// Honours MGT_WB_INITIATOR_TIMEOUT_EN when selecting timeout expectations.
module tb_mgt_wb_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mgt_wb_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .mgt_wb_clk_i (clk),
        .mgt_wb_rst_i (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_sel      (cmd_sel),
        .cmd_adr      (cmd_adr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_status   (rsp_status),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i)
    );

    // term: 0 = ack, 1 = err, 2 = ack and err together
    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] din;
        int          k;
        int          term;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
        int          exp_stb;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " cmd_ready"},  32'(cmd_ready),  32'h1);
        check({tag, " rsp_valid"},  32'(rsp_valid),  32'h0);
        check({tag, " rsp_rdata"},  rsp_rdata,       32'h0);
        check({tag, " rsp_status"}, 32'(rsp_status), 32'h0);
        check({tag, " cyc_stb_we"}, {29'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h0);
        check({tag, " sel"},        32'(wbm_sel_o),  32'h0);
        check({tag, " adr"},        wbm_adr_o,       32'h0);
        check({tag, " dat_o"},      wbm_dat_o,       32'h0);
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue_cmd(input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_sel   = sel;
        cmd_adr   = adr;
        cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called after a negedge with rsp_valid high; completes the response handshake.
    task automatic consume_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid_after_hs"}, 32'(rsp_valid), 32'h0);
        check({tag, " cmd_ready_after_hs"}, 32'(cmd_ready), 32'h1);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int cnt;
        bit stable;
        cnt    = 0;
        stable = 1'b1;
        check({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'h1);
        issue_cmd(v.we, v.sel, v.adr, v.wdata);
        for (int c = 0; c < v.k; c++) begin
            if (wbm_cyc_o && wbm_stb_o) cnt++;
            if (wbm_we_o !== v.we || wbm_sel_o !== v.sel ||
                wbm_adr_o !== v.adr || wbm_dat_o !== v.wdata || cmd_ready !== 1'b0)
                stable = 1'b0;
            if (c == v.k - 1) begin
                wbm_dat_i = v.din;
                wbm_ack_i = (v.term != 1);
                wbm_err_i = (v.term != 0);
            end
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;
        check({tag, " stb_cycles"}, 32'(cnt), 32'(v.exp_stb));
        check({tag, " bus_stable"}, 32'(stable), 32'h1);
        check({tag, " cyc_stb_end"}, {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, " rsp_status"}, 32'(rsp_status), 32'(v.exp_status));
        consume_rsp(tag);
    endtask

    initial begin
        int  cnt;
        bit  ok;
        logic [31:0] held;

        vecs[0] = '{1'b0, 4'hF,    32'h3000_0010, 32'h0,         32'hA5A5_1234, 1, 0, 32'hA5A5_1234, 2'b00, 1};
        vecs[1] = '{1'b1, 4'b0011, 32'h3000_0020, 32'hCAFE_F00D, 32'hDEAD_BEEF, 6, 0, 32'h0,         2'b00, 6};
        vecs[2] = '{1'b0, 4'hF,    32'h3000_0030, 32'h0,         32'h1111_2222, 2, 2, 32'h0,         2'b01, 2};
        vecs[3] = '{1'b1, 4'b1100, 32'h3000_0040, 32'h5555_AAAA, 32'h7777_8888, 3, 1, 32'h0,         2'b01, 3};
        vecs[4] = '{1'b0, 4'b1000, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 3, 0, 32'hFFFF_FFFF, 2'b00, 3};
        vecs[5] = '{1'b0, 4'b0001, 32'hFFFF_FFFC, 32'h0,         32'h0000_0001, 1, 0, 32'h0000_0001, 2'b00, 1};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0; cmd_adr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; wbm_dat_i = 32'h0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Stray terminations while idle must be ignored.
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h1234_5678;
        @(negedge clk);
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = 32'h0;
        @(negedge clk);
        check("stray rsp_valid", 32'(rsp_valid), 32'h0);
        check("stray cyc", 32'(wbm_cyc_o), 32'h0);
        check("stray cmd_ready", 32'(cmd_ready), 32'h1);

`ifdef MGT_WB_INITIATOR_TIMEOUT_EN
        // No ack ever: stb high TIMEOUT_CYCLES+1 = 5 cycles, then status 10.
        issue_cmd(1'b0, 4'hF, 32'h3000_0050, 32'h0);
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (!wbm_stb_o) break;
            cnt++;
            @(negedge clk);
        end
        check("timeout stb_cycles", 32'(cnt), 32'd5);
        check("timeout rsp_valid", 32'(rsp_valid), 32'h1);
        check("timeout rsp_status", 32'(rsp_status), 32'h2);
        check("timeout rsp_rdata", rsp_rdata, 32'h0);
        consume_rsp("timeout");
        @(negedge clk);
        // Ack landing on the timeout edge wins.
        run_vec("ack_at_timeout", '{1'b0, 4'hF, 32'h3000_0054, 32'h0, 32'h0BAD_F00D, 5, 0, 32'h0BAD_F00D, 2'b00, 5});
`else
        // Without the timeout the cycle waits indefinitely.
        issue_cmd(1'b0, 4'hF, 32'h3000_0050, 32'h0);
        repeat (1000) @(negedge clk);
        check("no_timeout stb_after_1000", 32'(wbm_stb_o), 32'h1);
        check("no_timeout rsp_valid", 32'(rsp_valid), 32'h0);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
        @(negedge clk);
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        check("no_timeout rsp_status", 32'(rsp_status), 32'h0);
        check("no_timeout rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        consume_rsp("no_timeout");
`endif
        @(negedge clk);

        // Backpressure: cmd_valid stays high, response held for 10 cycles.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0060; cmd_wdata = 32'h0;
        @(negedge clk);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h600D_CAFE;
        @(negedge clk);
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        held = rsp_rdata;
        check("bp rsp_rdata", held, 32'h600D_CAFE);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_status !== 2'b00 ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                ok = 1'b0;
            @(negedge clk);
        end
        check("bp held_stable", 32'(ok), 32'h1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp cyc_one_after", 32'(wbm_cyc_o), 32'h0);
        check("bp cmd_ready_one_after", 32'(cmd_ready), 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp cyc_two_after", 32'(wbm_cyc_o), 32'h1);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0002;
        @(negedge clk);
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        check("bp second rsp_rdata", rsp_rdata, 32'h0000_0002);
        consume_rsp("bp2");
        @(negedge clk);

        // One-cycle reset while a cycle is in progress.
        issue_cmd(1'b1, 4'b0110, 32'h3000_0070, 32'h1357_9BDF);
        check("midrst cyc_before", 32'(wbm_cyc_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");
        @(negedge clk);
        check("midrst cyc_stays_low", 32'(wbm_cyc_o), 32'h0);
        run_vec("after_rst", '{1'b0, 4'hF, 32'h3000_0080, 32'h0, 32'h2468_ACE0, 2, 0, 32'h2468_ACE0, 2'b00, 2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
